instr_loader: RTL and testbench
===============================

// Module: instr_loader
// PURPOSE
//  Boot-time writer for the DSP instruction memory (instrmem: 12-bit addr, 16-bit instr).
//  - Accepts a byte stream on a valid/ready handshake.
//  - Assembles big-endian 16-bit words and issues single-cycle writes at consecutive addresses.
//  - Validates an XOR checksum, then reports done or error.
//  - Holds the core in reset (cpu_hold) while a load is in progress.
// PARAMETERS
//  ADDR_W   12    instruction memory address width
//  DATA_W   16    instruction word width (fixed two bytes per word)
//  DEPTH    4096  maximum words per load (2**ADDR_W)
//  BASE     0     first write address
//  TIMEOUT  1024  idle cycles allowed between bytes mid-load before error
// PORTS
//  clk         in   1       system clock, all logic on rising edge
//  reset       in   1       synchronous, active-high
//  start       in   1       pulse: begin a load (ignored while busy)
//  byte_in     in   8       stream byte
//  byte_valid  in   1       byte_in valid this cycle
//  byte_ready  out  1       loader accepts byte this cycle (transfer = valid & ready)
//  wr_en       out  1       instruction memory write strobe
//  wr_addr     out  ADDR_W  write address
//  wr_data     out  DATA_W  write data
//  busy        out  1       load in progress
//  cpu_hold    out  1       equals busy; keeps processor in reset
//  done        out  1       one-cycle pulse: load completed, checksum good
//  error       out  1       sticky: bad length, checksum or timeout; cleared by start/reset
// BEHAVIOUR
//  Reset values
//  - All outputs 0; FSM in IDLE; word index, checksum and timeout counter cleared.
//  Stream format
//  - LEN_HI, LEN_LO: N words, big-endian.
//  - Per word: hi byte, then lo byte.
//  - CHK: XOR of every byte after start, LEN bytes included.
//  FSM states: IDLE, LEN_HI, LEN_LO, D_HI, D_LO, WRITE, CHK, DONE, ERR.
//  IDLE
//  - byte_ready=0; bytes are not consumed.
//  - On start: clear error, checksum, index -> LEN_HI.
//  LEN_HI / LEN_LO
//  - Each transfer latches a length byte and XORs it into the checksum.
//  - After LEN_LO: N==0 or N>DEPTH -> ERR; otherwise -> D_HI.
//  D_HI
//  - Transfer latches hi byte -> D_LO.
//  D_LO
//  - Transfer latches lo byte -> WRITE.
//  WRITE (exactly one cycle)
//  - byte_ready=0; wr_en=1.
//  - wr_addr = (BASE+index) mod 2**ADDR_W, so addresses wrap past 4095 to 0.
//  - wr_data = {hi,lo}; index++.
//  - Next state: index+1==N -> CHK, else D_HI.
//  - Write occurs the cycle after the lo-byte transfer (latency 1).
//  CHK
//  - Transfer compares the byte to the running XOR: equal -> DONE, else -> ERR.
//  - No memory write occurs on a checksum mismatch.
//  - Words already written stay in memory; error tells software to reload.
//  DONE
//  - done=1 for one cycle -> IDLE.
//  ERR
//  - error=1 (sticky) -> IDLE.
//  - error stays high until the next accepted start or reset.
//  busy / cpu_hold / byte_ready
//  - busy and cpu_hold are 1 in every state except IDLE; they drop to 0 the cycle after DONE/ERR.
//  - byte_ready=1 only in LEN_HI, LEN_LO, D_HI, D_LO and CHK.
//  Timeout
//  - Counter clears on each transfer and increments each busy cycle with no transfer.
//  - Reaching TIMEOUT -> ERR.
//  Boundary cases
//  - start while busy: ignored; the load continues.
//  - start together with reset: reset wins.
//  - byte_valid in WRITE: not consumed; the source holds the byte.
//  - reset mid-load: next cycle IDLE with wr_en=0; no further writes; partial contents untouched.
// TESTING
//  1. Basic load, start; stream 00 02 05 09 01 01 0E:
//     - wr_en: addr 0 = 0509, addr 1 = 0101.
//     - done pulses once; error=0; busy returns to 0.
//  2. Checksum error: same stream, final byte 0F:
//     - Both writes occur; error=1, no done.
//     - A following start clears error.
//  3. Bad length: 00 00 -> error=1, no wr_en. 10 01 (4097) -> error=1, no wr_en.
//  4. Backpressure and gaps:
//     - Hold byte_valid high through WRITE: byte_ready=0 there; no byte lost or duplicated.
//     - Random 0-20 cycle gaps: identical writes to test 1.
//  5. Timeout and reset:
//     - Stop after 00 02 05: error=1 exactly TIMEOUT idle cycles later.
//     - Reset asserted after first word: wr_en stays 0, busy=0 the next cycle.
//  6. Full load with BASE=4094, N=4 (words 0..3): writes land at 4094, 4095, 0, 1; done=1.

Source files
------------

// File: rtl/instr_loader.sv
// Boot-time instruction memory loader: takes a length-prefixed, XOR-checksummed byte
// stream and writes big-endian 16-bit words to consecutive addresses while holding the core.
module instr_loader #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 16,
    parameter int DEPTH   = 2 ** ADDR_W,
    parameter int BASE    = 0,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [7:0]        byte_in_i,
    input  logic              byte_valid_i,
    output logic              byte_ready_o,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [DATA_W-1:0] wr_data_o,
    output logic              busy_o,
    output logic              cpu_hold_o,
    output logic              done_o,
    output logic              error_o
);
    // state  | meaning
    // IDLE   | waiting for start, bytes not consumed
    // LEN_HI | expecting length high byte
    // LEN_LO | expecting length low byte, then length is validated
    // D_HI   | expecting word high byte
    // D_LO   | expecting word low byte
    // WRITE  | one-cycle memory write, stream stalled
    // CHK    | expecting checksum byte
    // DONE   | one-cycle done pulse
    // ERR    | error latched, returning to idle
    typedef enum logic [3:0] {
        IDLE, LEN_HI, LEN_LO, D_HI, D_LO, WRITE, CHK, DONE, ERR
    } state_t;

    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [16:0]       DEPTH_L = 17'(DEPTH);
    localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE);
    localparam logic [TMO_W-1:0]  TMO_L   = TMO_W'(TIMEOUT);

    state_t           state_q, state_d;
    logic [15:0]      len_q, len_d;
    logic [15:0]      idx_q, idx_d;
    logic [7:0]       hi_q, hi_d;
    logic [7:0]       lo_q, lo_d;
    logic [7:0]       chk_q, chk_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;

    logic        ready_c;
    logic        xfer_c;
    logic [15:0] len_c;
    logic [15:0] idx_inc_c;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            chk_q   <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            chk_q   <= chk_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        idx_d     = idx_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        chk_d     = chk_q;
        tmo_d     = tmo_q;
        err_d     = err_q;
        ready_c   = (state_q == LEN_HI) || (state_q == LEN_LO) || (state_q == D_HI) ||
                    (state_q == D_LO) || (state_q == CHK);
        xfer_c    = ready_c && byte_valid_i;
        len_c     = {len_q[15:8], byte_in_i};
        idx_inc_c = idx_q + 16'd1;

        if (state_q == IDLE || xfer_c) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + TMO_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    err_d   = 1'b0;
                    chk_d   = '0;
                    idx_d   = '0;
                    state_d = LEN_HI;
                end
            end
            LEN_HI: begin
                if (xfer_c) begin
                    len_d[15:8] = byte_in_i;
                    chk_d       = chk_q ^ byte_in_i;
                    state_d     = LEN_LO;
                end
            end
            LEN_LO: begin
                if (xfer_c) begin
                    len_d[7:0] = byte_in_i;
                    chk_d      = chk_q ^ byte_in_i;
                    if (len_c == 16'd0 || {1'b0, len_c} > DEPTH_L) begin
                        err_d   = 1'b1;
                        state_d = ERR;
                    end else begin
                        state_d = D_HI;
                    end
                end
            end
            D_HI: begin
                if (xfer_c) begin
                    hi_d    = byte_in_i;
                    chk_d   = chk_q ^ byte_in_i;
                    state_d = D_LO;
                end
            end
            D_LO: begin
                if (xfer_c) begin
                    lo_d    = byte_in_i;
                    chk_d   = chk_q ^ byte_in_i;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                idx_d   = idx_inc_c;
                state_d = (idx_inc_c == len_q) ? CHK : D_HI;
            end
            CHK: begin
                if (xfer_c) begin
                    if (byte_in_i == chk_q) begin
                        state_d = DONE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ERR;
                    end
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Stall watchdog only matters while waiting on the stream
        if (ready_c && !xfer_c && (tmo_q + TMO_W'(1)) == TMO_L) begin
            err_d   = 1'b1;
            state_d = ERR;
        end
    end

    assign byte_ready_o = ready_c;
    assign wr_en_o      = (state_q == WRITE);
    assign wr_addr_o    = (state_q == WRITE) ? BASE_A + idx_q[ADDR_W-1:0] : '0;
    assign wr_data_o    = (state_q == WRITE) ? DATA_W'({hi_q, lo_q}) : '0;
    assign busy_o       = (state_q != IDLE);
    assign cpu_hold_o   = (state_q != IDLE);
    assign done_o       = (state_q == DONE);
    assign error_o      = err_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: two instances (BASE 0 and BASE 4094) share one stream;
// writes, done pulses and flags are compared against hand-computed values.
module tb_instr_loader;
    logic clk = 1'b0;
    logic reset, start, byte_valid;
    logic [7:0] byte_in;

    logic a_ready, a_wr_en, a_busy, a_hold, a_done, a_error;
    logic [11:0] a_wr_addr;
    logic [15:0] a_wr_data;
    logic b_ready, b_wr_en, b_busy, b_hold, b_done, b_error;
    logic [11:0] b_wr_addr;
    logic [15:0] b_wr_data;

    int checks = 0;
    int failures = 0;
    logic [27:0] wa[$];
    logic [27:0] wb[$];
    int done_a = 0;
    int done_b = 0;
    int rdy_wr_a = 0;

    instr_loader #(.BASE(0)) u_dut_a (
        .clk_i(clk), .reset_i(reset), .start_i(start), .byte_in_i(byte_in),
        .byte_valid_i(byte_valid), .byte_ready_o(a_ready), .wr_en_o(a_wr_en),
        .wr_addr_o(a_wr_addr), .wr_data_o(a_wr_data), .busy_o(a_busy),
        .cpu_hold_o(a_hold), .done_o(a_done), .error_o(a_error)
    );

    instr_loader #(.BASE(4094)) u_dut_b (
        .clk_i(clk), .reset_i(reset), .start_i(start), .byte_in_i(byte_in),
        .byte_valid_i(byte_valid), .byte_ready_o(b_ready), .wr_en_o(b_wr_en),
        .wr_addr_o(b_wr_addr), .wr_data_o(b_wr_data), .busy_o(b_busy),
        .cpu_hold_o(b_hold), .done_o(b_done), .error_o(b_error)
    );

    always #5 clk = ~clk;

    // Mid-cycle observer of memory writes and done pulses
    always @(negedge clk) begin
        if (a_wr_en) begin
            wa.push_back({a_wr_addr, a_wr_data});
            if (a_ready) rdy_wr_a++;
        end
        if (b_wr_en) wb.push_back({b_wr_addr, b_wr_data});
        if (a_done) done_a++;
        if (b_done) done_b++;
    end

    task automatic clear_mon();
        wa.delete();
        wb.delete();
        done_a = 0;
        done_b = 0;
        rdy_wr_a = 0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        byte_valid = 1'b0;
        step(gap);
        byte_in = b;
        byte_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (a_ready) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        checks++;
        failures++;
        $display("FAIL send_byte_timeout byte=%02h never accepted within 200 cycles", b);
    endtask

    task automatic send_stream(input logic [7:0] s[$], input int maxgap);
        foreach (s[i]) send_byte(s[i], (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
        byte_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(3);
        checks++;
        if ({a_ready, a_wr_en, a_wr_addr, a_wr_data, a_busy, a_hold, a_done, a_error} !== 34'd0) begin
            failures++;
            $display("FAIL reset_outputs_a got %h exp 0",
                     {a_ready, a_wr_en, a_wr_addr, a_wr_data, a_busy, a_hold, a_done, a_error});
        end
        checks++;
        if ({b_ready, b_wr_en, b_wr_addr, b_wr_data, b_busy, b_hold, b_done, b_error} !== 34'd0) begin
            failures++;
            $display("FAIL reset_outputs_b got %h exp 0",
                     {b_ready, b_wr_en, b_wr_addr, b_wr_data, b_busy, b_hold, b_done, b_error});
        end
        reset = 1'b0;
        step(2);
        checks++;
        if (a_busy !== 1'b0 || a_ready !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset busy=%b ready=%b exp 0 0", a_busy, a_ready);
        end
    endtask

    task automatic check_basic_writes(input string tag);
        checks++;
        if (wa.size() !== 2) begin
            failures++;
            $display("FAIL %s_write_count got %0d exp 2", tag, wa.size());
        end
        checks++;
        if (wa[0] !== {12'd0, 16'h0509} || wa[1] !== {12'd1, 16'h0101}) begin
            failures++;
            $display("FAIL %s_write_data got %h %h exp 0000509 0010101", tag, wa[0], wa[1]);
        end
    endtask

    task automatic test_basic();
        logic [7:0] s[$];
        s = '{8'h00, 8'h02, 8'h05, 8'h09, 8'h01, 8'h01, 8'h0E};
        clear_mon();
        pulse_start();
        checks++;
        if (a_busy !== 1'b1 || a_hold !== 1'b1) begin
            failures++;
            $display("FAIL basic_busy_hold got %b%b exp 11", a_busy, a_hold);
        end
        send_stream(s, 0);
        step(3);
        check_basic_writes("basic");
        checks++;
        if (done_a !== 1 || a_error !== 1'b0 || a_busy !== 1'b0 || a_hold !== 1'b0) begin
            failures++;
            $display("FAIL basic_status done=%0d err=%b busy=%b hold=%b exp 1 0 0 0",
                     done_a, a_error, a_busy, a_hold);
        end
        checks++;
        if (rdy_wr_a !== 0) begin
            failures++;
            $display("FAIL basic_ready_in_write got %0d exp 0", rdy_wr_a);
        end
    endtask

    task automatic test_checksum_error();
        logic [7:0] s[$];
        s = '{8'h00, 8'h02, 8'h05, 8'h09, 8'h01, 8'h01, 8'h0F};
        clear_mon();
        pulse_start();
        send_stream(s, 0);
        step(3);
        check_basic_writes("chkerr");
        checks++;
        if (a_error !== 1'b1 || done_a !== 0) begin
            failures++;
            $display("FAIL chkerr_status err=%b done=%0d exp 1 0", a_error, done_a);
        end
        step(5);
        checks++;
        if (a_error !== 1'b1) begin
            failures++;
            $display("FAIL chkerr_sticky got %b exp 1", a_error);
        end
        pulse_start();
        checks++;
        if (a_error !== 1'b0 || a_busy !== 1'b1) begin
            failures++;
            $display("FAIL chkerr_start_clears err=%b busy=%b exp 0 1", a_error, a_busy);
        end
        do_reset();
    endtask

    task automatic test_bad_length();
        logic [7:0] s[$];
        clear_mon();
        s = '{8'h00, 8'h00};
        pulse_start();
        send_stream(s, 0);
        step(2);
        checks++;
        if (a_error !== 1'b1 || wa.size() !== 0 || a_busy !== 1'b0) begin
            failures++;
            $display("FAIL len_zero err=%b writes=%0d busy=%b exp 1 0 0", a_error, wa.size(), a_busy);
        end
        s = '{8'h10, 8'h01};
        pulse_start();
        checks++;
        if (a_error !== 1'b0) begin
            failures++;
            $display("FAIL len_restart_clear got %b exp 0", a_error);
        end
        send_stream(s, 0);
        step(2);
        checks++;
        if (a_error !== 1'b1 || wa.size() !== 0 || done_a !== 0) begin
            failures++;
            $display("FAIL len_4097 err=%b writes=%0d done=%0d exp 1 0 0", a_error, wa.size(), done_a);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] s[$];
        s = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hFF, 8'h00, 8'hBC};
        clear_mon();
        pulse_start();
        send_stream(s, 0);
        step(3);
        checks++;
        if (wa.size() !== 3 || wa[0] !== {12'd0, 16'h1234} || wa[1] !== {12'd1, 16'hABCD} ||
            wa[2] !== {12'd2, 16'hFF00}) begin
            failures++;
            $display("FAIL b2b_writes n=%0d got %h %h %h exp 0001234 001ABCD 002FF00",
                     wa.size(), wa[0], wa[1], wa[2]);
        end
        checks++;
        if (done_a !== 1 || a_error !== 1'b0 || rdy_wr_a !== 0) begin
            failures++;
            $display("FAIL b2b_status done=%0d err=%b ready_in_write=%0d exp 1 0 0",
                     done_a, a_error, rdy_wr_a);
        end
    endtask

    task automatic test_gaps();
        logic [7:0] s[$];
        s = '{8'h00, 8'h02, 8'h05, 8'h09, 8'h01, 8'h01, 8'h0E};
        clear_mon();
        pulse_start();
        send_stream(s, 20);
        step(3);
        check_basic_writes("gaps");
        checks++;
        if (done_a !== 1 || a_error !== 1'b0) begin
            failures++;
            $display("FAIL gaps_status done=%0d err=%b exp 1 0", done_a, a_error);
        end
    endtask

    task automatic test_start_ignored();
        logic [7:0] s[$];
        clear_mon();
        pulse_start();
        s = '{8'h00, 8'h01};
        send_stream(s, 0);
        pulse_start();
        s = '{8'h12, 8'h34, 8'h27};
        send_stream(s, 0);
        step(3);
        checks++;
        if (wa.size() !== 1 || wa[0] !== {12'd0, 16'h1234} || done_a !== 1 || a_error !== 1'b0) begin
            failures++;
            $display("FAIL start_busy n=%0d w=%h done=%0d err=%b exp 1 0001234 1 0",
                     wa.size(), wa[0], done_a, a_error);
        end
    endtask

    task automatic test_timeout();
        logic [7:0] s[$];
        int k;
        s = '{8'h00, 8'h02, 8'h05};
        clear_mon();
        pulse_start();
        send_stream(s, 0);
        for (k = 1; k <= 1100; k++) begin
            step(1);
            if (a_error) break;
        end
        checks++;
        if (k !== 1024) begin
            failures++;
            $display("FAIL timeout_cycles got %0d exp 1024", k);
        end
        step(2);
        checks++;
        if (wa.size() !== 0 || a_busy !== 1'b0 || a_error !== 1'b1) begin
            failures++;
            $display("FAIL timeout_status writes=%0d busy=%b err=%b exp 0 0 1", wa.size(), a_busy, a_error);
        end
    endtask

    task automatic test_reset_midload();
        logic [7:0] s[$];
        s = '{8'h00, 8'h02, 8'h05, 8'h09};
        clear_mon();
        pulse_start();
        send_stream(s, 0);
        step(1);
        reset = 1'b1;
        step(1);
        checks++;
        if (a_busy !== 1'b0 || a_hold !== 1'b0 || a_wr_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid busy=%b hold=%b wr_en=%b exp 0 0 0", a_busy, a_hold, a_wr_en);
        end
        start = 1'b1;
        step(1);
        checks++;
        if (a_busy !== 1'b0) begin
            failures++;
            $display("FAIL start_with_reset busy got %b exp 0", a_busy);
        end
        start = 1'b0;
        reset = 1'b0;
        step(4);
        checks++;
        if (wa.size() !== 1 || wa[0] !== {12'd0, 16'h0509} || a_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_writes n=%0d w=%h busy=%b exp 1 0000509 0", wa.size(), wa[0], a_busy);
        end
    endtask

    task automatic test_base_wrap();
        logic [7:0] s[$];
        logic [27:0] exp_b[4];
        s = '{8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h04};
        exp_b = '{{12'd4094, 16'h0000}, {12'd4095, 16'h0001}, {12'd0, 16'h0002}, {12'd1, 16'h0003}};
        clear_mon();
        pulse_start();
        send_stream(s, 0);
        step(3);
        checks++;
        if (wb.size() !== 4) begin
            failures++;
            $display("FAIL wrap_count got %0d exp 4", wb.size());
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (wb[i] !== exp_b[i]) begin
                failures++;
                $display("FAIL wrap_write%0d got %h exp %h", i, wb[i], exp_b[i]);
            end
        end
        checks++;
        if (done_b !== 1 || b_error !== 1'b0 || wa[3] !== {12'd3, 16'h0003}) begin
            failures++;
            $display("FAIL wrap_status done=%0d err=%b a3=%h exp 1 0 0030003", done_b, b_error, wa[3]);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        byte_valid = 1'b0;
        byte_in = 8'h00;
        test_reset();
        test_basic();
        test_checksum_error();
        test_bad_length();
        test_back_to_back();
        test_gaps();
        test_start_ignored();
        test_timeout();
        test_reset_midload();
        test_base_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
